// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions for the MEM/WB consumer: default widths,
// the hardwired-zero register index and the write-back select encoding.
package wb_regfile_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        MEM2R_ALU = 1'b0,
        MEM2R_MEM = 1'b1
    } mem2r_e;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_wb_mux.sv
// Write-back select: picks load data or the ALU result and flags whether
// the MEM/WB entry actually targets a writable register.
module wb_mux
    import wb_regfile_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          regw_i,
    input  logic          mem2r_i,
    input  logic [AW-1:0] rd_i,
    input  logic [DW-1:0] dm_out_i,
    input  logic [DW-1:0] alu_out_i,
    output logic [DW-1:0] wb_data_o,
    output logic          wb_valid_o
);

    // Data select and write qualification
    always_comb begin
        wb_data_o  = alu_out_i;
        wb_valid_o = regw_i & (rd_i != AW'(REG_ZERO));
        case (mem2r_e'(mem2r_i))
            MEM2R_MEM: wb_data_o = dm_out_i;
            MEM2R_ALU: wb_data_o = alu_out_i;
            default:   wb_data_o = alu_out_i;
        endcase
    end

endmodule : wb_mux

// File: rtl/wb_regfile.sv
// Write-back stage merged with the architectural register file: commits the
// selected MEM/WB result, serves two ID read ports plus a debug port.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int BYPASS = 1,
    parameter int CW     = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          RegRegW,
    input  logic          RegMem2R,
    input  logic [AW-1:0] RegRd,
    input  logic [DW-1:0] RegDmOut,
    input  logic [DW-1:0] RegAluOut,
    input  logic [AW-1:0] RsAddr,
    input  logic [AW-1:0] RtAddr,
    output logic [DW-1:0] RsData,
    output logic [DW-1:0] RtData,
    output logic [DW-1:0] WbData,
    output logic          WbValid,
    input  logic [AW-1:0] DbgAddr,
    output logic [DW-1:0] DbgData,
    output logic [CW-1:0] WbCount
);

    localparam int NREG = 2 ** AW;

    logic [DW-1:0] wb_data_s;
    logic          wb_valid_s;
    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [DW-1:0] rs_data_s;
    logic [DW-1:0] rt_data_s;
    logic [DW-1:0] dbg_data_s;

    wb_mux #(.DW(DW), .AW(AW)) u_wb_mux (
        .regw_i    (RegRegW),
        .mem2r_i   (RegMem2R),
        .rd_i      (RegRd),
        .dm_out_i  (RegDmOut),
        .alu_out_i (RegAluOut),
        .wb_data_o (wb_data_s),
        .wb_valid_o(wb_valid_s)
    );

    // Next-state for the register array and retired-write counter
    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        if (wb_valid_s) begin
            regs_d[RegRd] = wb_data_s;
            cnt_d         = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            regs_d = regs_q;
            cnt_d  = cnt_q;
        end
    end

    // Storage: async clear; entry 0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '{default: '0};
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

    // Read ports: zero register first, then same-cycle bypass, then storage
    always_comb begin
        rs_data_s  = regs_q[RsAddr];
        rt_data_s  = regs_q[RtAddr];
        dbg_data_s = regs_q[DbgAddr];
        if (RsAddr == AW'(REG_ZERO)) begin
            rs_data_s = '0;
        end else if ((BYPASS != 0) && wb_valid_s && (RsAddr == RegRd)) begin
            rs_data_s = wb_data_s;
        end else begin
            rs_data_s = regs_q[RsAddr];
        end
        if (RtAddr == AW'(REG_ZERO)) begin
            rt_data_s = '0;
        end else if ((BYPASS != 0) && wb_valid_s && (RtAddr == RegRd)) begin
            rt_data_s = wb_data_s;
        end else begin
            rt_data_s = regs_q[RtAddr];
        end
        if (DbgAddr == AW'(REG_ZERO)) begin
            dbg_data_s = '0;
        end else begin
            dbg_data_s = regs_q[DbgAddr];
        end
    end

    assign RsData  = rs_data_s;
    assign RtData  = rt_data_s;
    assign DbgData = dbg_data_s;
    assign WbData  = wb_data_s;
    assign WbValid = wb_valid_s;
    assign WbCount = cnt_q;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Directed bench: one bypassing 4-bit-counter instance and one non-bypassing
// 32-bit-counter instance share all inputs.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegRegW;
    logic        RegMem2R;
    logic [4:0]  RegRd;
    logic [31:0] RegDmOut;
    logic [31:0] RegAluOut;
    logic [4:0]  RsAddr;
    logic [4:0]  RtAddr;
    logic [4:0]  DbgAddr;

    logic [31:0] RsData, RtData, WbData, DbgData;
    logic        WbValid;
    logic [3:0]  WbCount;
    logic [31:0] nb_RsData, nb_RtData, nb_WbData, nb_DbgData;
    logic        nb_WbValid;
    logic [31:0] nb_WbCount;

    int checks = 0;
    int errors = 0;

    wb_regfile #(.DW(32), .AW(5), .BYPASS(1), .CW(4)) dut (
        .clk(clk), .rst(rst), .RegRegW(RegRegW), .RegMem2R(RegMem2R),
        .RegRd(RegRd), .RegDmOut(RegDmOut), .RegAluOut(RegAluOut),
        .RsAddr(RsAddr), .RtAddr(RtAddr), .RsData(RsData), .RtData(RtData),
        .WbData(WbData), .WbValid(WbValid), .DbgAddr(DbgAddr),
        .DbgData(DbgData), .WbCount(WbCount)
    );

    wb_regfile #(.DW(32), .AW(5), .BYPASS(0), .CW(32)) dut_nb (
        .clk(clk), .rst(rst), .RegRegW(RegRegW), .RegMem2R(RegMem2R),
        .RegRd(RegRd), .RegDmOut(RegDmOut), .RegAluOut(RegAluOut),
        .RsAddr(RsAddr), .RtAddr(RtAddr), .RsData(nb_RsData), .RtData(nb_RtData),
        .WbData(nb_WbData), .WbValid(nb_WbValid), .DbgAddr(DbgAddr),
        .DbgData(nb_DbgData), .WbCount(nb_WbCount)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_wb(input logic [4:0] rd, input logic m2r,
                            input logic [31:0] alu, input logic [31:0] dm);
        RegRegW   = 1'b1;
        RegRd     = rd;
        RegMem2R  = m2r;
        RegAluOut = alu;
        RegDmOut  = dm;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_wb(5'd5, 1'b0, 32'h0000_0055, 32'h0000_0066);
        RsAddr = 5'd5; RtAddr = 5'd5; DbgAddr = 5'd5;
        repeat (3) cycle();
        checks++;
        if (DbgData !== 32'h0) begin errors++; $display("FAIL reset_dbg5 got %h exp %h", DbgData, 32'h0); end
        checks++;
        if (nb_RsData !== 32'h0) begin errors++; $display("FAIL reset_rs5 got %h exp %h", nb_RsData, 32'h0); end
        checks++;
        if (WbCount !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", WbCount); end
        rst = 1'b1;
        cycle();
        RegRegW = 1'b0;
        #1;
        checks++;
        if (DbgData !== 32'h0000_0055) begin errors++; $display("FAIL release_dbg5 got %h exp %h", DbgData, 32'h55); end
        checks++;
        if (WbCount !== 4'd1) begin errors++; $display("FAIL release_cnt got %0d exp 1", WbCount); end
    endtask

    task automatic test_select();
        drive_wb(5'd8, 1'b0, 32'h0000_1234, 32'hDEAD_BEEF);
        DbgAddr = 5'd8;
        #1;
        checks++;
        if (WbData !== 32'h0000_1234 || WbValid !== 1'b1) begin
            errors++; $display("FAIL sel_alu_wb got %h/%b exp 00001234/1", WbData, WbValid);
        end
        cycle();
        RegRegW = 1'b0;
        #1;
        checks++;
        if (DbgData !== 32'h0000_1234) begin errors++; $display("FAIL sel_alu_reg8 got %h exp 00001234", DbgData); end
        drive_wb(5'd9, 1'b1, 32'h0000_1234, 32'hDEAD_BEEF);
        DbgAddr = 5'd9;
        #1;
        checks++;
        if (WbData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sel_mem_wb got %h exp deadbeef", WbData); end
        cycle();
        RegRegW = 1'b0;
        #1;
        checks++;
        if (DbgData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sel_mem_reg9 got %h exp deadbeef", DbgData); end
        checks++;
        if (WbCount !== 4'd3) begin errors++; $display("FAIL sel_cnt got %0d exp 3", WbCount); end
    endtask

    task automatic test_bypass();
        drive_wb(5'd3, 1'b0, 32'h1111_1111, 32'h0);
        cycle();
        drive_wb(5'd3, 1'b0, 32'hCAFE_F00D, 32'h0);
        RsAddr = 5'd3; RtAddr = 5'd3; DbgAddr = 5'd3;
        #1;
        checks++;
        if (RsData !== 32'hCAFE_F00D || RtData !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL bypass_rs_rt got %h/%h exp cafef00d", RsData, RtData);
        end
        checks++;
        if (DbgData !== 32'h1111_1111) begin errors++; $display("FAIL bypass_dbg_old got %h exp 11111111", DbgData); end
        checks++;
        if (nb_RsData !== 32'h1111_1111 || nb_RtData !== 32'h1111_1111) begin
            errors++; $display("FAIL nobypass_old got %h/%h exp 11111111", nb_RsData, nb_RtData);
        end
        cycle();
        RegRegW = 1'b0;
        #1;
        checks++;
        if (DbgData !== 32'hCAFE_F00D) begin errors++; $display("FAIL bypass_dbg_new got %h exp cafef00d", DbgData); end
        checks++;
        if (nb_RsData !== 32'hCAFE_F00D) begin errors++; $display("FAIL nobypass_new got %h exp cafef00d", nb_RsData); end
        checks++;
        if (WbCount !== 4'd5) begin errors++; $display("FAIL bypass_cnt got %0d exp 5", WbCount); end
    endtask

    task automatic test_reg0();
        drive_wb(5'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        RsAddr = 5'd0; RtAddr = 5'd0; DbgAddr = 5'd0;
        #1;
        checks++;
        if (WbValid !== 1'b0) begin errors++; $display("FAIL r0_valid got %b exp 0", WbValid); end
        checks++;
        if (RsData !== 32'h0 || RtData !== 32'h0) begin
            errors++; $display("FAIL r0_read got %h/%h exp 0", RsData, RtData);
        end
        cycle();
        RegRegW = 1'b0;
        #1;
        checks++;
        if (DbgData !== 32'h0 || WbCount !== 4'd5) begin
            errors++; $display("FAIL r0_after got %h cnt %0d exp 0 cnt 5", DbgData, WbCount);
        end
    endtask

    task automatic test_wrap();
        drive_wb(5'd10, 1'b0, 32'h0000_0A0A, 32'h0);
        RegRegW = 1'b0;
        DbgAddr = 5'd10;
        cycle();
        checks++;
        if (WbCount !== 4'd5 || DbgData !== 32'h0) begin
            errors++; $display("FAIL nowrite got cnt %0d dbg %h exp 5/0", WbCount, DbgData);
        end
        for (int i = 1; i <= 17; i++) begin
            drive_wb(5'(i), 1'b0, 32'h0000_0100 + 32'(i), 32'h0);
            cycle();
        end
        RegRegW = 1'b0;
        DbgAddr = 5'd17;
        #1;
        checks++;
        if (WbCount !== 4'd6) begin errors++; $display("FAIL wrap_cnt got %0d exp 6", WbCount); end
        checks++;
        if (nb_WbCount !== 32'd22) begin errors++; $display("FAIL wide_cnt got %0d exp 22", nb_WbCount); end
        checks++;
        if (DbgData !== 32'h0000_0111) begin errors++; $display("FAIL wrap_reg17 got %h exp 00000111", DbgData); end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 31; i++) begin
            drive_wb(5'(i), 1'b1, 32'h0, 32'hA000_0000 | 32'(i));
            cycle();
        end
        RegRegW = 1'b0;
        RsAddr = 5'd7; RtAddr = 5'd31; DbgAddr = 5'd31;
        #1;
        checks++;
        if (DbgData !== 32'hA000_001F || nb_RsData !== 32'hA000_0007 || WbCount !== 4'd5) begin
            errors++; $display("FAIL pre_areset got %h %h cnt %0d exp a000001f a0000007 5", DbgData, nb_RsData, WbCount);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (DbgData !== 32'h0 || RsData !== 32'h0 || RtData !== 32'h0 || nb_RtData !== 32'h0) begin
            errors++; $display("FAIL areset_regs got %h %h %h %h exp 0", DbgData, RsData, RtData, nb_RtData);
        end
        checks++;
        if (WbCount !== 4'd0 || nb_WbCount !== 32'd0) begin
            errors++; $display("FAIL areset_cnt got %0d/%0d exp 0/0", WbCount, nb_WbCount);
        end
        cycle();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; RegRegW = 1'b0; RegMem2R = 1'b0; RegRd = 5'd0;
        RegDmOut = 32'h0; RegAluOut = 32'h0;
        RsAddr = 5'd0; RtAddr = 5'd0; DbgAddr = 5'd0;
        #1;
        test_reset();
        test_select();
        test_bypass();
        test_reg0();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_wb_regfile

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: the write-back stage merged with the architectural register file.
- Each cycle it takes the latched MEM/WB fields and selects the write-back data (memory load or ALU result).
- It commits that data to the 32-entry general-purpose register file and serves the two ID-stage read ports.
- Internal write-before-read bypass covers a WB write and an ID read of the same register in the same cycle.
- Also provides a debug read port and a retired-write counter for the bench.

Parameters:
- DW, 32, data width of registers and data paths
- AW, 5, register address width (2**AW registers; register 0 hardwired to zero)
- BYPASS, 1, 1 = same-cycle WB-to-ID bypass on read ports; 0 = read ports show the stored value only
- CW, 32, width of the retired-write counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- RegRegW  input  1  write-back enable from MEM/WB
- RegMem2R  input  1  1 = write DmOut, 0 = write AluOut
- RegRd  input  AW  destination register from MEM/WB
- RegDmOut  input  DW  load data from MEM/WB
- RegAluOut  input  DW  ALU result from MEM/WB
- RsAddr  input  AW  ID read port A address
- RtAddr  input  AW  ID read port B address
- RsData  output  DW  read port A data
- RtData  output  DW  read port B data
- WbData  output  DW  selected write-back data, also sent to the forwarding unit
- WbValid  output  1  1 when RegRegW=1 and RegRd!=0
- DbgAddr  input  AW  debug read address
- DbgData  output  DW  debug read data, no bypass
- WbCount  output  CW  number of committed register writes

Behaviour:
- Reset:
  - rst=0 immediately (asynchronously) clears registers 1..2**AW-1 and WbCount to 0.
  - While rst=0, no write commits regardless of RegRegW.
  - Reset asserted mid-operation discards the in-flight write of that edge.
  - Deassertion is taken synchronously at the first rising edge with rst=1.
- Write-back data select, combinational: WbData = RegMem2R ? RegDmOut : RegAluOut.
- WbValid = RegRegW & (RegRd != 0), combinational.
- Commit: at a rising clk edge with rst=1 and WbValid=1, reg[RegRd] <= WbData and WbCount <= WbCount+1.
- WbCount wraps modulo 2**CW with no saturation.
- Writes to register 0 are ignored and do not increment WbCount.
- Read ports are combinational, zero latency:
  - Address 0 always returns 0, with or without bypass.
  - If BYPASS=1, WbValid=1 and RsAddr==RegRd, then RsData = WbData; otherwise RsData = reg[RsAddr]. Same rule for Rt.
  - Both ports may hit the same register and the bypass simultaneously; both return WbData.
  - With BYPASS=0, a read of the register being written returns the old value until after the edge.
- DbgData = reg[DbgAddr] (0 for address 0), never bypassed.
- No X propagation: all storage is reset, and outputs are defined at all times after reset.

Decomposition:
- Shared pipeline package holds:
  - the DW/AW defaults;
  - REG_ZERO constant (5'd0);
  - the write-back select encoding (MEM2R_ALU=0, MEM2R_MEM=1), shared with the control unit and MEM_WB.
- One natural sub-module: wb_mux, the combinational write-back select (DmOut vs AluOut) producing WbData and WbValid.
- The register array, bypass compare and counter stay in wb_regfile.

Test Plan:
- Reset: hold rst=0 with RegRegW=1, RegRd=5 and clocks running -> RsData(5)=0 and WbCount=0. Release rst, next edge -> reg5=AluOut, WbCount=1.
- ALU vs load select: RegMem2R=0, AluOut=32'h0000_1234, DmOut=32'hDEAD_BEEF, Rd=8 -> reg8=32'h1234. Then RegMem2R=1, Rd=9 -> reg9=32'hDEADBEEF, WbCount=2.
- Same-cycle bypass, BYPASS=1: write 32'hCAFE_F00D to Rd=3 while RsAddr=RtAddr=3 -> RsData=RtData=32'hCAFEF00D before the edge. DbgData(3) shows the old value until after the edge.
- Register 0: RegRegW=1, Rd=0, AluOut=32'hFFFF_FFFF -> reads of address 0 return 0, WbValid=0, WbCount unchanged.
- Counter wrap: CW=4, perform 17 valid writes -> WbCount=1. With RegRegW=0, no write and no increment.
- Async reset mid-stream: after writes to regs 1..31, pulse rst=0 between edges -> all reads return 0 and WbCount=0 immediately, without waiting for a clock edge.
